risk_tile_mem: RTL and testbench
================================

Name: risk_tile_mem

Overview:
- Parametrised successor of the RISK banked strided-tile memory.
- Loads or stores one SZ x SZ tile of BITS-bit elements at element addresses base + stride_x*x + stride_y*y across 2^LOGBANK single-port banks.
- Bank conflicts are detected and serialised over multiple passes instead of being silently dropped.
- Sits between the RISK register file and on-chip BRAM, with valid/ready handshakes on both request and response.

Parameters:
- SZ, 4, tile edge; the tile has SZ*SZ elements, k = y*SZ + x.
- BITS, 18, element width.
- LOGBANK, 5, log2 of the bank count (32 banks).
- LOGDEPTH, 10, log2 of words per bank.
- SW, 14, stride width.
- AW, LOGBANK+LOGDEPTH, element address width (derived).
- PW, $clog2(SZ*SZ)+1, pass-count width (derived).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  tile base element address.
- req_stride_x  in  SW  address step per x.
- req_stride_y  in  SW  address step per y.
- req_wdata  in  BITS*SZ*SZ  store data; element k at [BITS*k +: BITS].
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  BITS*SZ*SZ  load data, same packing as req_wdata; all zero for stores.
- resp_passes  out  PW  bank passes the request used (1..SZ*SZ).
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (resetn low, async): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_passes=0, busy=0, pending mask cleared. Bank contents are not reset and are retained across reset.
- FSM states: IDLE -> ADDR -> ISSUE -> DRAIN -> RESP -> IDLE.
- req_ready = (state==IDLE). Request fields are captured at the accepting edge T0; inputs are ignored afterwards.
- ADDR (edge T1):
  - Register e(k) = (req_addr + stride_x*x + stride_y*y) mod 2^AW, i.e. wrap-around, strides unsigned.
  - bank(k) = e(k)[LOGBANK-1:0]; row(k) = e(k)[AW-1:LOGBANK].
  - pending = all ones; pass counter = 0.
- ISSUE, one pass per cycle:
  - Every bank selects the lowest-index pending k with bank(k) equal to that bank and performs one read or write at row(k).
  - Selected bits are cleared from pending; the pass counter increments.
  - When pending becomes zero, go to DRAIN.
  - Pass count N equals the maximum number of elements mapped to any single bank.
- Bank reads have 1-cycle latency. Read data is written into resp_rdata slot k on the edge after its pass.
- DRAIN: captures data from the final pass, then enters RESP.
- Timing: resp_valid rises at edge T0+N+2 and is held with stable data until resp_ready. On consumption, go to IDLE; req_ready is high in the following cycle, with no back-to-back accept.
- Stores with duplicate element addresses: serialised in index order, so the highest k is written last and wins.
- Loads with duplicate element addresses: every duplicate slot returns the same word.
- A load issued after a store completes observes that store.
- Reset asserted mid-operation aborts the request: no response is generated; bank writes already issued persist; unissued writes are dropped.
- All address arithmetic is done at AW bits; products are truncated.

Test Plan:
- Store tile data k+1 at addr 0, stride_x=1, stride_y=4 -> resp_passes=1, resp_valid at T0+3. Load with the same params -> resp_rdata element k = k+1, resp_passes=1.
- Load addr 0, stride_x=32, stride_y=128 (all elements in bank 0) -> resp_passes=16, resp_valid at T0+18, data correct.
- Load addr 0, stride_x=16, stride_y=1 (two elements per bank) -> resp_passes=2, resp_valid at T0+4.
- Store addr 0x7FFF, stride_x=1 -> element 1 wraps to address 0. Reload from addr 0 stride 1 -> element 0 holds the data of original k=1.
- Store with stride_x=0, stride_y=0, data k -> resp_passes=16. Subsequent load returns 15 in every slot.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0. Then drop resetn during ISSUE of a 16-pass store -> outputs reset immediately, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/risk_tile_mem.sv
// risk_tile_mem: SZ x SZ strided tile load/store over 2^LOGBANK
// single-port banks; bank conflicts are serialised over passes.
module risk_tile_mem #(
  parameter int SZ       = 4,
  parameter int BITS     = 18,
  parameter int LOGBANK  = 5,
  parameter int LOGDEPTH = 10,
  parameter int SW       = 14,
  parameter int AW       = LOGBANK + LOGDEPTH,
  parameter int PW       = $clog2(SZ*SZ) + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [SW-1:0]        req_stride_x,
  input  logic [SW-1:0]        req_stride_y,
  input  logic [BITS*SZ*SZ-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BITS*SZ*SZ-1:0] resp_rdata,
  output logic [PW-1:0]        resp_passes,
  output logic                 busy
);

  localparam int NE    = SZ * SZ;
  localparam int NB    = 1 << LOGBANK;
  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int KW    = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ISSUE,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t                 r_state;
  logic                   r_we;
  logic [AW-1:0]          r_addr;
  logic [SW-1:0]          r_sx;
  logic [SW-1:0]          r_sy;
  logic [BITS*NE-1:0]     r_wdata;
  logic [AW*NE-1:0]       r_e;
  logic [AW*NE-1:0]       w_e;
  logic [NE-1:0]          r_pend;
  logic [NE-1:0]          w_clr;
  logic [NE-1:0]          w_pend_nx;
  logic [PW-1:0]          r_pcnt;
  logic [NB-1:0]          w_en;
  logic [NB-1:0]          r_rvld;
  logic [NB*KW-1:0]       w_sel;
  logic [NB*KW-1:0]       r_rk;
  logic [NB*LOGDEPTH-1:0] w_row;
  logic [NB*BITS-1:0]     w_wd;
  logic [NB*BITS-1:0]     w_rd;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic                   r_busy;
  logic [BITS*NE-1:0]     r_rdata;
  logic [PW-1:0]          r_passes;

  always_comb begin
    w_e = '0;
    for (int y = 0; y < SZ; y++) begin
      for (int x = 0; x < SZ; x++) begin
        w_e[(y*SZ+x)*AW +: AW] = r_addr
          + AW'(r_sx) * AW'(x)
          + AW'(r_sy) * AW'(y);
      end
    end
  end

  // an element issues when no lower pending index shares its bank
  always_comb begin
    logic hit;
    w_clr = '0;
    for (int k = 0; k < NE; k++) begin
      hit = (r_state == S_ISSUE) && r_pend[k];
      for (int j = 0; j < k; j++) begin
        if (r_pend[j] &&
            r_e[j*AW +: LOGBANK] == r_e[k*AW +: LOGBANK])
          hit = 1'b0;
      end
      w_clr[k] = hit;
    end
  end

  assign w_pend_nx = r_pend & ~w_clr;

  always_comb begin
    w_en  = '0;
    w_sel = '0;
    w_row = '0;
    w_wd  = '0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NE; k++) begin
        if (w_clr[k] &&
            r_e[k*AW +: LOGBANK] == LOGBANK'(b)) begin
          w_en[b] = 1'b1;
          w_sel[b*KW +: KW] = KW'(k);
          w_row[b*LOGDEPTH +: LOGDEPTH] =
            r_e[k*AW+LOGBANK +: LOGDEPTH];
          w_wd[b*BITS +: BITS] = r_wdata[k*BITS +: BITS];
        end
      end
    end
  end

  for (genvar gb = 0; gb < NB; gb++) begin : g_bank
    logic [BITS-1:0] r_mem [DEPTH];
    logic [BITS-1:0] r_q;

    always_ff @(posedge clk) begin
      if (w_en[gb]) begin
        if (r_we)
          r_mem[w_row[gb*LOGDEPTH +: LOGDEPTH]] <=
            w_wd[gb*BITS +: BITS];
        else
          r_q <= r_mem[w_row[gb*LOGDEPTH +: LOGDEPTH]];
      end
    end

    assign w_rd[gb*BITS +: BITS] = r_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_sx         <= '0;
      r_sy         <= '0;
      r_wdata      <= '0;
      r_e          <= '0;
      r_pend       <= '0;
      r_pcnt       <= '0;
      r_rvld       <= '0;
      r_rk         <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_rdata      <= '0;
      r_passes     <= '0;
    end else begin
      r_rvld <= (r_state == S_ISSUE && !r_we) ? w_en : '0;
      r_rk   <= w_sel;
      // read data lands one edge after its pass
      for (int b = 0; b < NB; b++) begin
        if (r_rvld[b])
          r_rdata[int'(r_rk[b*KW +: KW])*BITS +: BITS] <=
            w_rd[b*BITS +: BITS];
      end
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_sx        <= req_stride_x;
            r_sy        <= req_stride_y;
            r_wdata     <= req_wdata;
            r_rdata     <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_e     <= w_e;
          r_pend  <= '1;
          r_pcnt  <= '0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_pend <= w_pend_nx;
          r_pcnt <= r_pcnt + PW'(1);
          if (w_pend_nx == '0)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_resp_valid <= 1'b1;
          r_passes     <= r_pcnt;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_rdata;
  assign resp_passes = r_passes;
  assign busy        = r_busy;

endmodule

// File: tb/tb_risk_tile_mem.sv
// tb_risk_tile_mem: directed load/store vectors with
// hand-computed expectations for risk_tile_mem.
module tb_risk_tile_mem;

  localparam int BITS = 18;
  localparam int NE   = 16;
  localparam int AW   = 15;
  localparam int SW   = 14;
  localparam int PW   = 5;
  localparam int DW   = BITS * NE;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [SW-1:0] req_stride_x = '0;
  logic [SW-1:0] req_stride_y = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic [PW-1:0] resp_passes;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  risk_tile_mem dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_stride_x (req_stride_x),
    .req_stride_y (req_stride_y),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_passes  (resp_passes),
    .busy         (busy)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] tile(input int base,
                                         input int step);
    logic [DW-1:0] t;
    t = '0;
    for (int k = 0; k < NE; k++)
      t[k*BITS +: BITS] = BITS'(base + step * k);
    return t;
  endfunction

  task automatic xact(input logic we,
                      input logic [AW-1:0] addr,
                      input logic [SW-1:0] sx,
                      input logic [SW-1:0] sy,
                      input logic [DW-1:0] wd,
                      input int hold,
                      output int lat,
                      output logic [PW-1:0] passes,
                      output logic [DW-1:0] rd);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_stride_x = sx;
    req_stride_y = sy;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      chk("hold valid", DW'(resp_valid), DW'(1));
      chk("hold req_ready", DW'(req_ready), DW'(0));
      chk("hold busy", DW'(busy), DW'(1));
    end
    passes = resp_passes;
    rd     = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("idle req_ready", DW'(req_ready), DW'(1));
  endtask

  initial begin
    int            lat;
    logic [PW-1:0] p;
    logic [DW-1:0] rd;
    logic [DW-1:0] ex;
    logic          seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", DW'(req_ready), DW'(1));
    chk("rst resp_valid", DW'(resp_valid), DW'(0));
    chk("rst busy", DW'(busy), DW'(0));
    chk("rst passes", DW'(resp_passes), DW'(0));
    chk("rst rdata", resp_rdata, '0);
    @(negedge clk);
    resetn = 1'b1;

    xact(1'b1, 15'h0, 14'd1, 14'd4, tile(1, 1), 0, lat, p, rd);
    chk("st1 lat", DW'(lat), DW'(3));
    chk("st1 passes", DW'(p), DW'(1));
    chk("st1 rdata", rd, '0);
    xact(1'b0, 15'h0, 14'd1, 14'd4, '0, 0, lat, p, rd);
    chk("ld1 lat", DW'(lat), DW'(3));
    chk("ld1 passes", DW'(p), DW'(1));
    chk("ld1 rdata", rd, tile(1, 1));

    xact(1'b1, 15'h0, 14'd32, 14'd128, tile(100, 1), 0,
         lat, p, rd);
    chk("st32 passes", DW'(p), DW'(16));
    xact(1'b0, 15'h0, 14'd32, 14'd128, '0, 0, lat, p, rd);
    chk("ld32 lat", DW'(lat), DW'(18));
    chk("ld32 passes", DW'(p), DW'(16));
    chk("ld32 rdata", rd, tile(100, 1));

    xact(1'b1, 15'h0, 14'd16, 14'd1, tile(200, 1), 0,
         lat, p, rd);
    chk("st16 passes", DW'(p), DW'(2));
    xact(1'b0, 15'h0, 14'd16, 14'd1, '0, 0, lat, p, rd);
    chk("ld16 lat", DW'(lat), DW'(4));
    chk("ld16 passes", DW'(p), DW'(2));
    chk("ld16 rdata", rd, tile(200, 1));

    xact(1'b1, 15'h7fff, 14'd1, 14'd4, tile(300, 1), 0,
         lat, p, rd);
    chk("stwrap passes", DW'(p), DW'(1));
    xact(1'b0, 15'h0, 14'd1, 14'd4, '0, 0, lat, p, rd);
    ex = tile(301, 1);
    ex[15*BITS +: BITS] = 18'd16;
    chk("ldwrap rdata", rd, ex);

    xact(1'b1, 15'h100, 14'd0, 14'd0, tile(0, 1), 0,
         lat, p, rd);
    chk("stdup lat", DW'(lat), DW'(18));
    chk("stdup passes", DW'(p), DW'(16));
    xact(1'b0, 15'h100, 14'd0, 14'd0, '0, 5, lat, p, rd);
    chk("lddup passes", DW'(p), DW'(16));
    chk("lddup rdata", rd, tile(15, 0));

    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_addr     = 15'h200;
    req_stride_x = 14'd0;
    req_stride_y = 14'd0;
    req_wdata    = tile(500, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("abort req_ready", DW'(req_ready), DW'(1));
    chk("abort resp_valid", DW'(resp_valid), DW'(0));
    chk("abort busy", DW'(busy), DW'(0));
    chk("abort passes", DW'(resp_passes), DW'(0));
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (resp_valid || busy) seen = 1'b1;
    end
    chk("abort no resp", DW'(seen), DW'(0));
    xact(1'b0, 15'h200, 14'd0, 14'd0, '0, 0, lat, p, rd);
    chk("abort partial", rd, tile(503, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
